// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with parallel load, wrap or saturate at the bounds,
// and registered one-cycle carry/borrow pulses for cascading.
module updown_counter_n #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX      = 2**WIDTH - 1,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sel,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_zero,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
    localparam logic             SAT_V = (SATURATE != 0);

    // Reject configurations outside the supported range at elaboration.
    if (WIDTH < 2 || MAX < 1 || (64'(MAX) >> WIDTH) != 64'd0) begin : g_param_check
        $error("updown_counter_n: unsupported WIDTH/MAX combination");
    end

    logic [WIDTH-1:0] out_nxt;
    logic             carry_nxt;
    logic             borrow_nxt;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        out_nxt    = out;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        if (load) begin
            out_nxt = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (sel) begin
                if (out == MAX_V) begin
                    carry_nxt = 1'b1;
                    out_nxt   = SAT_V ? MAX_V : '0;
                end else begin
                    out_nxt = out + ONE_V;
                end
            end else begin
                if (out == '0) begin
                    borrow_nxt = 1'b1;
                    out_nxt    = SAT_V ? '0 : MAX_V;
                end else begin
                    out_nxt = out - ONE_V;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out    <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            out    <= out_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

    assign at_max  = (out == MAX_V);
    assign at_zero = (out == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: a wrap and a saturate instance (WIDTH=4, MAX=9) share stimulus;
// an arithmetic model is compared every cycle and directed sequences pin literal values.
module tb_updown_counter_n;

    localparam int W   = 4;
    localparam int MAX = 9;

    logic         clk = 1'b0;
    logic         reset, en, sel, load;
    logic [W-1:0] load_val;
    logic [W-1:0] out_w, out_s;
    logic         at_max_w, at_zero_w, carry_w, borrow_w;
    logic         at_max_s, at_zero_s, carry_s, borrow_s;

    int checks = 0;
    int errors = 0;

    updown_counter_n #(.WIDTH(W), .MAX(MAX), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load), .load_val(load_val),
        .out(out_w), .at_max(at_max_w), .at_zero(at_zero_w), .carry(carry_w), .borrow(borrow_w)
    );

    updown_counter_n #(.WIDTH(W), .MAX(MAX), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .en(en), .sel(sel), .load(load), .load_val(load_val),
        .out(out_s), .at_max(at_max_s), .at_zero(at_zero_s), .carry(carry_s), .borrow(borrow_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain modular / clamped arithmetic on the count value.
    int mw, ms, mcw, mbw, mcs, mbs;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mw <= 0; ms <= 0;
            mcw <= 0; mbw <= 0; mcs <= 0; mbs <= 0;
            m_valid <= 1'b1;
        end else if (load) begin
            mw <= (int'(load_val) > MAX) ? MAX : int'(load_val);
            ms <= (int'(load_val) > MAX) ? MAX : int'(load_val);
            mcw <= 0; mbw <= 0; mcs <= 0; mbs <= 0;
        end else if (en && sel) begin
            mw  <= (mw + 1) % (MAX + 1);
            ms  <= (ms + 1 > MAX) ? MAX : ms + 1;
            mcw <= int'(mw == MAX); mcs <= int'(ms == MAX);
            mbw <= 0; mbs <= 0;
        end else if (en) begin
            mw  <= (mw + MAX) % (MAX + 1);
            ms  <= (ms - 1 < 0) ? 0 : ms - 1;
            mbw <= int'(mw == 0); mbs <= int'(ms == 0);
            mcw <= 0; mcs <= 0;
        end else begin
            mcw <= 0; mbw <= 0; mcs <= 0; mbs <= 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_out_w",     int'(out_w),     mw);
            chk("model_carry_w",   int'(carry_w),   mcw);
            chk("model_borrow_w",  int'(borrow_w),  mbw);
            chk("model_at_max_w",  int'(at_max_w),  int'(mw == MAX));
            chk("model_at_zero_w", int'(at_zero_w), int'(mw == 0));
            chk("model_out_s",     int'(out_s),     ms);
            chk("model_carry_s",   int'(carry_s),   mcs);
            chk("model_borrow_s",  int'(borrow_s),  mbs);
            chk("model_at_max_s",  int'(at_max_s),  int'(ms == MAX));
            chk("model_at_zero_s", int'(at_zero_s), int'(ms == 0));
            chk("model_excl_w",    int'(carry_w & borrow_w), 0);
            chk("model_excl_s",    int'(carry_s & borrow_s), 0);
        end
    end

    // Apply inputs just after a falling edge, then advance through one rising edge.
    task automatic step(input logic r, input logic l, input logic e, input logic s, input int lv);
        reset = r; load = l; en = e; sel = s; load_val = W'(lv);
        @(negedge clk); #1;
    endtask

    int up_w[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int up_s[12]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    int dn_w[5]   = '{2, 1, 0, 9, 8};
    int dn_s[5]   = '{2, 1, 0, 0, 0};
    int sat_w[4]  = '{9, 0, 1, 2};

    initial begin
        reset = 1'b1; load = 1'b0; en = 1'b0; sel = 1'b0; load_val = '0;
        @(negedge clk); #1;
        step(1, 0, 0, 0, 0);
        chk("rst_out_w", int'(out_w), 0);
        chk("rst_zero_w", int'(at_zero_w), 1);
        chk("rst_max_w", int'(at_max_w), 0);
        chk("rst_pulse_s", int'(carry_s | borrow_s), 0);

        // Count up 12 cycles from 0.
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1, 1, 0);
            chk("up_out_w", int'(out_w), up_w[i]);
            chk("up_carry_w", int'(carry_w), int'(i == 9));
            chk("up_out_s", int'(out_s), up_s[i]);
            chk("up_carry_s", int'(carry_s), int'(i >= 9));
        end

        // Load 3, count down 5 cycles.
        step(0, 1, 0, 0, 3);
        chk("ld3_out_w", int'(out_w), 3);
        chk("ld3_out_s", int'(out_s), 3);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0, 0);
            chk("dn_out_w", int'(out_w), dn_w[i]);
            chk("dn_borrow_w", int'(borrow_w), int'(i == 3));
            chk("dn_zero_w", int'(at_zero_w), int'(i == 2));
            chk("dn_out_s", int'(out_s), dn_s[i]);
            chk("dn_borrow_s", int'(borrow_s), int'(i >= 3));
        end

        // Load 8, count up 4 cycles, then reverse once.
        step(0, 1, 0, 0, 8);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, 1, 0);
            chk("sat_out_s", int'(out_s), 9);
            chk("sat_max_s", int'(at_max_s), 1);
            chk("sat_carry_s", int'(carry_s), int'(i >= 1));
            chk("sat_out_w", int'(out_w), sat_w[i]);
            chk("sat_carry_w", int'(carry_w), int'(i == 1));
        end
        step(0, 0, 1, 0, 0);
        chk("rev_out_s", int'(out_s), 8);
        chk("rev_carry_s", int'(carry_s), 0);
        chk("rev_out_w", int'(out_w), 1);

        // Over-range load clamps; load beats enable.
        step(0, 1, 0, 0, 15);
        chk("clamp_out_w", int'(out_w), 9);
        chk("clamp_max_w", int'(at_max_w), 1);
        step(0, 1, 1, 1, 4);
        chk("ldwin_out_w", int'(out_w), 4);
        chk("ldwin_pulse_w", int'(carry_w | borrow_w), 0);
        step(0, 1, 1, 1, 9);
        chk("ldmax_out_s", int'(out_s), 9);
        step(0, 1, 1, 1, 10);
        chk("ldmax_carry_s", int'(carry_s), 0);

        // Reset mid-count together with load, then held with enable.
        step(0, 1, 0, 0, 5);
        step(0, 0, 1, 1, 0);
        chk("mid_out_w", int'(out_w), 6);
        step(1, 1, 1, 1, 7);
        chk("rstld_out_w", int'(out_w), 0);
        chk("rstld_pulse_w", int'(carry_w | borrow_w), 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, i[0], 0);
            chk("rsthold_out_w", int'(out_w), 0);
            chk("rsthold_out_s", int'(out_s), 0);
        end

        // Hold at 5 with sel toggling.
        step(0, 1, 0, 0, 5);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, i[0], 0);
            chk("hold_out_w", int'(out_w), 5);
            chk("hold_pulse_w", int'(carry_w | borrow_w), 0);
            chk("hold_out_s", int'(out_s), 5);
        end

        // Direction flip right at the boundary.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("flip_out_w", int'(out_w), 9);
        chk("flip_borrow_w", int'(borrow_w), 1);
        step(0, 0, 1, 1, 0);
        chk("flip2_out_w", int'(out_w), 0);
        chk("flip2_carry_w", int'(carry_w), 1);
        chk("flip2_borrow_w", int'(borrow_w), 0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
